// File: rtl/alu_dec_md_pkg.sv
// Shared encodings for the ALU/mult-div decoder: MIPS opcode and funct
// fields, ALU operation codes, mult/div class codes and sequencer states.
package alu_dec_md_pkg;

  // Primary opcode field (instruction bits 31:26)
  localparam logic [5:0] OPC_RTYPE  = 6'h00;
  localparam logic [5:0] OPC_REGIMM = 6'h01; // BLTZ/BGEZ
  localparam logic [5:0] OPC_BLEZ   = 6'h06;
  localparam logic [5:0] OPC_BGTZ   = 6'h07;
  localparam logic [5:0] OPC_ADDIU  = 6'h09;
  localparam logic [5:0] OPC_SLTI   = 6'h0A;
  localparam logic [5:0] OPC_SLTIU  = 6'h0B;
  localparam logic [5:0] OPC_ANDI   = 6'h0C;
  localparam logic [5:0] OPC_ORI    = 6'h0D;
  localparam logic [5:0] OPC_XORI   = 6'h0E;
  localparam logic [5:0] OPC_LUI    = 6'h0F;
  localparam logic [5:0] OPC_LB     = 6'h20;
  localparam logic [5:0] OPC_LH     = 6'h21;
  localparam logic [5:0] OPC_LW     = 6'h23;
  localparam logic [5:0] OPC_LBU    = 6'h24;
  localparam logic [5:0] OPC_LHU    = 6'h25;
  localparam logic [5:0] OPC_SB     = 6'h28;
  localparam logic [5:0] OPC_SH     = 6'h29;
  localparam logic [5:0] OPC_SW     = 6'h2B;

  // R-type funct field (instruction bits 5:0)
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // ALU operation codes; zero is deliberately unused so a stuck-at-zero
  // output never looks like a valid ADDU
  typedef enum logic [3:0] {
    ALU_ADDU = 4'd1,
    ALU_SUBU = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_NOR  = 4'd6,
    ALU_SLT  = 4'd7,
    ALU_SLTU = 4'd8,
    ALU_SLL  = 4'd9,
    ALU_SRL  = 4'd10,
    ALU_SRA  = 4'd11,
    ALU_LUI  = 4'd12
  } alu_op_e;

  // Mult/div class; MTHI and MTLO share one code
  typedef enum logic [2:0] {
    MD_NONE   = 3'd0,
    MD_MULT   = 3'd1,
    MD_MULTU  = 3'd2,
    MD_DIV    = 3'd3,
    MD_DIVU   = 3'd4,
    MD_MFHI   = 3'd5,
    MD_MFLO   = 3'd6,
    MD_MTHILO = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } md_state_e;

  typedef struct packed {
    alu_op_e alu;
    md_op_e  md;
    logic    ill;
  } dec_t;

  // Classes that launch the iterative multiply/divide sequencer
  function automatic logic is_md_seq(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/alu_dec_md_md_seq.sv
// md_seq: multiply/divide occupancy sequencer (IDLE -> BUSY -> DONE).
// Tracks MD_CYCLES iterations and emits start/busy/done status.
module md_seq
  import alu_dec_md_pkg::*;
#(
  parameter int MD_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  output logic o_start,
  output logic o_busy,
  output logic o_done
);

  localparam int CNT_W = $clog2(MD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_CYCLES - 1);

  md_state_e        r_state;
  md_state_e        w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_start;

  // Next-state and counter: the count runs regardless of pipeline stall
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_state_next = S_BUSY;
          w_cnt_next   = CNT_LOAD;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_BUSY: begin
        if (r_cnt == '0) w_state_next = S_DONE;
        else             w_cnt_next   = r_cnt - 1'b1;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State, counter and start-pulse registers; reset aborts any operation
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_start <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_start <= i_start && (r_state != S_BUSY);
    end
  end

  assign o_start = r_start;
  assign o_busy  = (r_state == S_BUSY);
  assign o_done  = (r_state == S_DONE);

endmodule

// File: rtl/alu_dec_md.sv
// alu_dec_md: registered ALU / mult-div decoder with HI/LO hazard gating.
// Build option: define MD_DIV_EN to decode and sequence DIV/DIVU; without
// it those functs decode as illegal and never start the sequencer.
module alu_dec_md
  import alu_dec_md_pkg::*;
#(
  parameter int MD_CYCLES = 32,
  parameter int OP_W      = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      opcode,
  input  logic [5:0]      funct,
  input  logic            stall,
  input  logic            flush,
  output logic            out_valid,
  output logic [OP_W-1:0] alu_op,
  output logic [2:0]      md_op,
  output logic            md_start,
  output logic            md_busy,
  output logic            md_done,
  output logic            illegal
);

  dec_t    w_dec;
  logic    w_busy;
  logic    w_hazard;
  logic    w_accept;
  logic    w_md_go;
  logic    r_out_valid;
  alu_op_e r_alu_op;
  md_op_e  r_md_op;
  logic    r_illegal;

  // Decode table: anything not listed is illegal with ADDU/NONE
  always_comb begin
    w_dec = '{ALU_ADDU, MD_NONE, 1'b1};
    case (opcode)
      OPC_RTYPE: begin
        case (funct)
          FN_SLL, FN_SLLV:   w_dec = '{ALU_SLL,  MD_NONE,   1'b0};
          FN_SRL, FN_SRLV:   w_dec = '{ALU_SRL,  MD_NONE,   1'b0};
          FN_SRA, FN_SRAV:   w_dec = '{ALU_SRA,  MD_NONE,   1'b0};
          FN_ADDU:           w_dec = '{ALU_ADDU, MD_NONE,   1'b0};
          FN_SUBU:           w_dec = '{ALU_SUBU, MD_NONE,   1'b0};
          FN_AND:            w_dec = '{ALU_AND,  MD_NONE,   1'b0};
          FN_OR:             w_dec = '{ALU_OR,   MD_NONE,   1'b0};
          FN_XOR:            w_dec = '{ALU_XOR,  MD_NONE,   1'b0};
          FN_NOR:            w_dec = '{ALU_NOR,  MD_NONE,   1'b0};
          FN_SLT:            w_dec = '{ALU_SLT,  MD_NONE,   1'b0};
          FN_SLTU:           w_dec = '{ALU_SLTU, MD_NONE,   1'b0};
          FN_MFHI:           w_dec = '{ALU_ADDU, MD_MFHI,   1'b0};
          FN_MFLO:           w_dec = '{ALU_ADDU, MD_MFLO,   1'b0};
          FN_MTHI, FN_MTLO:  w_dec = '{ALU_ADDU, MD_MTHILO, 1'b0};
          FN_MULT:           w_dec = '{ALU_ADDU, MD_MULT,   1'b0};
          FN_MULTU:          w_dec = '{ALU_ADDU, MD_MULTU,  1'b0};
`ifdef MD_DIV_EN
          FN_DIV:            w_dec = '{ALU_ADDU, MD_DIV,    1'b0};
          FN_DIVU:           w_dec = '{ALU_ADDU, MD_DIVU,   1'b0};
`else
          FN_DIV, FN_DIVU:   w_dec = '{ALU_ADDU, MD_NONE,   1'b1};
`endif
          default:           w_dec = '{ALU_ADDU, MD_NONE,   1'b1};
        endcase
      end
      OPC_LB, OPC_LH, OPC_LW, OPC_LBU, OPC_LHU,
      OPC_SB, OPC_SH, OPC_SW, OPC_ADDIU:
                             w_dec = '{ALU_ADDU, MD_NONE,   1'b0};
      OPC_SLTI, OPC_BLEZ, OPC_BGTZ, OPC_REGIMM:
                             w_dec = '{ALU_SLT,  MD_NONE,   1'b0};
      OPC_SLTIU:             w_dec = '{ALU_SLTU, MD_NONE,   1'b0};
      OPC_ANDI:              w_dec = '{ALU_AND,  MD_NONE,   1'b0};
      OPC_ORI:               w_dec = '{ALU_OR,   MD_NONE,   1'b0};
      OPC_XORI:              w_dec = '{ALU_XOR,  MD_NONE,   1'b0};
      OPC_LUI:               w_dec = '{ALU_LUI,  MD_NONE,   1'b0};
      default:               w_dec = '{ALU_ADDU, MD_NONE,   1'b1};
    endcase
  end

  // Any HI/LO-touching instruction must wait while the unit is occupied;
  // flush does not gate ready, it only discards what is accepted.
  assign w_hazard = w_busy && (w_dec.md != MD_NONE);
  assign in_ready = !stall && !w_hazard;
  assign w_accept = in_valid && in_ready && !flush;
  assign w_md_go  = w_accept && is_md_seq(w_dec.md);

  // Output register: flush clears, stall holds, otherwise load or drain
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_alu_op    <= ALU_ADDU;
      r_md_op     <= MD_NONE;
      r_illegal   <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (!stall) begin
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_alu_op  <= w_dec.alu;
        r_md_op   <= w_dec.md;
        r_illegal <= w_dec.ill;
      end
    end
  end

  md_seq #(
    .MD_CYCLES (MD_CYCLES)
  ) u_md_seq (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_md_go),
    .o_start (md_start),
    .o_busy  (w_busy),
    .o_done  (md_done)
  );

  assign md_busy   = w_busy;
  assign out_valid = r_out_valid;
  assign alu_op    = OP_W'(r_alu_op);
  assign md_op     = r_md_op;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_dec_md.sv
// Scoreboard bench for alu_dec_md: the driver queues the expected decode for
// each instruction it issues; the monitor pops on every freshly loaded output.
module tb_alu_dec_md;
  import alu_dec_md_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic       out_valid;
  logic [3:0] alu_op;
  logic [2:0] md_op;
  logic       md_start, md_busy, md_done, illegal;

  typedef struct packed {
    logic [3:0] alu;
    logic [2:0] md;
    logic       ill;
    logic       start;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_txn = 0;
  logic stall_q = 1'b0;
  logic flush_q = 1'b0;
  logic rst_q   = 1'b1;

`ifdef MD_DIV_EN
  localparam logic [5:0] SEC_FN = FN_DIVU;
  localparam logic [2:0] SEC_MD = MD_DIVU;
`else
  localparam logic [5:0] SEC_FN = FN_MULT;
  localparam logic [2:0] SEC_MD = MD_MULT;
`endif

  alu_dec_md #(.MD_CYCLES(32), .OP_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .stall(stall), .flush(flush),
    .out_valid(out_valid), .alu_op(alu_op), .md_op(md_op),
    .md_start(md_start), .md_busy(md_busy), .md_done(md_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction for one cycle and queue its expected decode
  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [3:0] ea,
                       input logic [2:0] em, input logic ei, input logic es);
    opcode   = op;
    funct    = fn;
    in_valid = 1'b1;
    sb_q.push_back('{ea, em, ei, es});
    next_cycle();
    in_valid = 1'b0;
  endtask

  // Monitor: an output is fresh when the previous cycle was neither stalled,
  // flushed nor in reset and out_valid is now high
  always @(negedge clk) begin
    logic fresh;
    exp_t e;
    fresh = out_valid && !stall_q && !flush_q && !rst_q;
    if (fresh) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got alu_op=%0d md_op=%0d expected nothing queued", alu_op, md_op);
      end else begin
        e = sb_q.pop_front();
        n_txn++;
        chk("alu_op", alu_op, e.alu);
        chk("md_op", md_op, e.md);
        chk("illegal", illegal, e.ill);
        chk("md_start", md_start, e.start);
        $display("txn %0d: alu_op=%0d md_op=%0d illegal=%0b md_start=%0b", n_txn, alu_op, md_op, illegal, md_start);
      end
    end else if (md_start) begin
      chk("md_start_stray", md_start, 1'b0);
    end
    stall_q = stall;
    flush_q = flush;
    rst_q   = rst;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    // Reset values
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_alu_op", alu_op, ALU_ADDU);
    chk("rst_md_op", md_op, MD_NONE);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_md_start", md_start, 1'b0);
    chk("rst_md_busy", md_busy, 1'b0);
    chk("rst_md_done", md_done, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // ADDU then LUI back-to-back, out_valid steady, then drains
    opcode = OPC_RTYPE; funct = FN_ADDU; in_valid = 1'b1;
    sb_q.push_back('{ALU_ADDU, MD_NONE, 1'b0, 1'b0});
    next_cycle();
    opcode = OPC_LUI; funct = 6'h00;
    sb_q.push_back('{ALU_LUI, MD_NONE, 1'b0, 1'b0});
    @(negedge clk);
    chk("b2b_valid_1", out_valid, 1'b1);
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid_2", out_valid, 1'b1);
    next_cycle();
    @(negedge clk);
    chk("drain_valid", out_valid, 1'b0);
    next_cycle();

    // Decode table, back-to-back
    issue(OPC_RTYPE, FN_SRAV, ALU_SRA,  MD_NONE,   1'b0, 1'b0);
    issue(OPC_RTYPE, FN_SLLV, ALU_SLL,  MD_NONE,   1'b0, 1'b0);
    issue(OPC_RTYPE, FN_SRL,  ALU_SRL,  MD_NONE,   1'b0, 1'b0);
    issue(OPC_RTYPE, FN_SUBU, ALU_SUBU, MD_NONE,   1'b0, 1'b0);
    issue(OPC_RTYPE, FN_NOR,  ALU_NOR,  MD_NONE,   1'b0, 1'b0);
    issue(OPC_RTYPE, FN_SLTU, ALU_SLTU, MD_NONE,   1'b0, 1'b0);
    issue(OPC_RTYPE, FN_SLT,  ALU_SLT,  MD_NONE,   1'b0, 1'b0);
    issue(OPC_LW,    FN_MULT, ALU_ADDU, MD_NONE,   1'b0, 1'b0);
    issue(OPC_SW,    6'h00,   ALU_ADDU, MD_NONE,   1'b0, 1'b0);
    issue(OPC_SLTI,  6'h00,   ALU_SLT,  MD_NONE,   1'b0, 1'b0);
    issue(OPC_SLTIU, 6'h00,   ALU_SLTU, MD_NONE,   1'b0, 1'b0);
    issue(OPC_XORI,  6'h00,   ALU_XOR,  MD_NONE,   1'b0, 1'b0);
    issue(OPC_ANDI,  6'h00,   ALU_AND,  MD_NONE,   1'b0, 1'b0);
    issue(OPC_BGTZ,  6'h00,   ALU_SLT,  MD_NONE,   1'b0, 1'b0);
    issue(OPC_REGIMM,6'h00,   ALU_SLT,  MD_NONE,   1'b0, 1'b0);
    issue(6'h3F,     6'h00,   ALU_ADDU, MD_NONE,   1'b1, 1'b0);
    issue(OPC_RTYPE, 6'h01,   ALU_ADDU, MD_NONE,   1'b1, 1'b0);
    issue(OPC_RTYPE, FN_MFHI, ALU_ADDU, MD_MFHI,   1'b0, 1'b0);
    issue(OPC_RTYPE, FN_MTLO, ALU_ADDU, MD_MTHILO, 1'b0, 1'b0);
    issue(OPC_RTYPE, FN_MTHI, ALU_ADDU, MD_MTHILO, 1'b0, 1'b0);
    next_cycle();

    // Stall holds the output register and blocks acceptance
    issue(OPC_RTYPE, FN_XOR, ALU_XOR, MD_NONE, 1'b0, 1'b0);
    opcode = OPC_RTYPE; funct = FN_OR; in_valid = 1'b1; stall = 1'b1;
    @(negedge clk);
    chk("stall_ready", in_ready, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("stall_hold_valid", out_valid, 1'b1);
    chk("stall_hold_alu", alu_op, ALU_XOR);
    next_cycle();
    stall = 1'b0;
    sb_q.push_back('{ALU_OR, MD_NONE, 1'b0, 1'b0});
    @(negedge clk);
    chk("unstall_ready", in_ready, 1'b1);
    next_cycle();
    in_valid = 1'b0;
    next_cycle();

    // Flush kills an instruction being accepted
    issue(OPC_RTYPE, FN_AND, ALU_AND, MD_NONE, 1'b0, 1'b0);
    opcode = OPC_ORI; funct = 6'h00; in_valid = 1'b1; flush = 1'b1;
    next_cycle();
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_accept_valid", out_valid, 1'b0);
    next_cycle();

    // Flush overrides stall
    issue(OPC_RTYPE, FN_XOR, ALU_XOR, MD_NONE, 1'b0, 1'b0);
    stall = 1'b1; flush = 1'b1;
    next_cycle();
    stall = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_stall_valid", out_valid, 1'b0);
    next_cycle();

    // Flushed MULT never starts the sequencer
    opcode = OPC_RTYPE; funct = FN_MULT; in_valid = 1'b1; flush = 1'b1;
    next_cycle();
    in_valid = 1'b0; flush = 1'b0; funct = 6'h00;
    @(negedge clk);
    chk("flush_mult_start", md_start, 1'b0);
    chk("flush_mult_busy", md_busy, 1'b0);
    chk("flush_mult_valid", out_valid, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("flush_mult_busy2", md_busy, 1'b0);
    next_cycle();

    // MULT: 32 busy cycles, done pulse; MFLO held off until DONE.
    // A flush mid-operation must not disturb the sequencer.
    issue(OPC_RTYPE, FN_MULT, ALU_ADDU, MD_MULT, 1'b0, 1'b1);
    opcode = OPC_RTYPE; funct = 6'h00;
    for (int k = 0; k <= 36; k++) begin
      if (k == 3) begin
        funct = FN_MFLO; in_valid = 1'b1;
        sb_q.push_back('{ALU_ADDU, MD_MFLO, 1'b0, 1'b0});
      end
      if (k == 5) flush = 1'b1;
      if (k == 6) flush = 1'b0;
      if (k == 33) begin in_valid = 1'b0; funct = 6'h00; end
      @(negedge clk);
      chk("mult_busy", md_busy, k <= 31);
      chk("mult_done", md_done, k == 32);
      chk("mult_in_ready", in_ready, (k >= 3 && k <= 31) ? 1'b0 : 1'b1);
      next_cycle();
    end

    // Second mult/div accepted in DONE: busy again with no IDLE gap
    issue(OPC_RTYPE, FN_MULTU, ALU_ADDU, MD_MULTU, 1'b0, 1'b1);
    funct = 6'h00;
    for (int k = 0; k <= 67; k++) begin
      if (k == 32) begin
        funct = SEC_FN; in_valid = 1'b1;
        sb_q.push_back('{ALU_ADDU, SEC_MD, 1'b0, 1'b1});
      end
      if (k == 33) begin in_valid = 1'b0; funct = 6'h00; end
      @(negedge clk);
      chk("b2b_busy", md_busy, (k <= 31) || (k >= 33 && k <= 64));
      chk("b2b_done", md_done, (k == 32) || (k == 65));
      next_cycle();
    end

    // Reset in the middle of a MULT aborts it with no done pulse
    issue(OPC_RTYPE, FN_MULT, ALU_ADDU, MD_MULT, 1'b0, 1'b1);
    funct = 6'h00;
    for (int k = 0; k <= 45; k++) begin
      if (k == 5) begin
        opcode = OPC_XORI; in_valid = 1'b1;
        sb_q.push_back('{ALU_XOR, MD_NONE, 1'b0, 1'b0});
      end
      if (k == 6) begin in_valid = 1'b0; opcode = OPC_RTYPE; stall = 1'b1; end
      if (k == 10) rst = 1'b1;
      if (k == 11) begin rst = 1'b0; stall = 1'b0; end
      @(negedge clk);
      if (k == 9) chk("rst_pre_hold_alu", alu_op, ALU_XOR);
      if (k < 11) chk("rst_pre_busy", md_busy, 1'b1);
      if (k == 11) begin
        chk("rst_mid_valid", out_valid, 1'b0);
        chk("rst_mid_alu", alu_op, ALU_ADDU);
        chk("rst_mid_md", md_op, MD_NONE);
        chk("rst_mid_illegal", illegal, 1'b0);
        chk("rst_mid_start", md_start, 1'b0);
      end
      if (k >= 11) begin
        chk("rst_post_busy", md_busy, 1'b0);
        chk("rst_post_done", md_done, 1'b0);
      end
      next_cycle();
    end

    // DIV handling depends on the build option
`ifdef MD_DIV_EN
    issue(OPC_RTYPE, FN_DIV, ALU_ADDU, MD_DIV, 1'b0, 1'b1);
    funct = 6'h00;
    for (int k = 0; k <= 34; k++) begin
      @(negedge clk);
      chk("div_busy", md_busy, k <= 31);
      chk("div_done", md_done, k == 32);
      next_cycle();
    end
`else
    issue(OPC_RTYPE, FN_DIV, ALU_ADDU, MD_NONE, 1'b1, 1'b0);
    funct = 6'h00;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      chk("div_off_busy", md_busy, 1'b0);
      next_cycle();
    end
`endif

    next_cycle();
    next_cycle();
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
